// File: rtl/branch_resolution_queue.sv
// In-order queue of predicted branches between fetch and execute.
// Owns the speculative GHR and restores it on a mispredict.
module branch_resolution_queue #(
    parameter int HISTORY_LEN = 8,
    parameter int DEPTH       = 4,
    parameter int PC_W        = 16
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push_valid,
    input  logic [PC_W-1:0]          push_pc,
    input  logic                     push_prediction,
    output logic                     push_ready,
    output logic [HISTORY_LEN-1:0]   spec_history,
    input  logic                     resolve_valid,
    input  logic                     resolve_taken,
    output logic                     upd_write_enabled,
    output logic [PC_W-1:0]          upd_pc,
    output logic [HISTORY_LEN-1:0]   upd_history,
    output logic                     upd_outcome,
    output logic                     mispredict,
    output logic                     resolve_err,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     empty,
    output logic                     full
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [PC_W-1:0]        pc_mem   [DEPTH];
    logic [HISTORY_LEN-1:0] hist_mem [DEPTH];
    logic                   pred_mem [DEPTH];

    logic [PTR_W-1:0] head;
    logic [PTR_W-1:0] tail;
    logic [CNT_W-1:0] count_nxt;

    logic do_resolve;
    logic do_mis;
    logic do_push;
    logic do_pop;

    assign empty      = (count == '0);
    assign full       = (count == CNT_W'(DEPTH));
    assign push_ready = !full;

    // A mispredict flushes everything, so it also kills a same-cycle push.
    assign do_resolve = resolve_valid && !empty;
    assign do_mis     = do_resolve && (resolve_taken != pred_mem[head]);
    assign do_push    = push_valid && push_ready && !do_mis;
    assign do_pop     = do_resolve && !do_mis;

    always_comb begin
        count_nxt = count;
        unique case (1'b1)
            do_mis:             count_nxt = '0;
            do_push && !do_pop: count_nxt = count + 1'b1;
            !do_push && do_pop: count_nxt = count - 1'b1;
            default:            count_nxt = count;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            head         <= '0;
            tail         <= '0;
            count        <= '0;
            spec_history <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                pc_mem[i]   <= '0;
                hist_mem[i] <= '0;
                pred_mem[i] <= 1'b0;
            end
        end else begin
            count <= count_nxt;
            if (do_mis) begin
                head         <= tail;
                spec_history <= {hist_mem[head][HISTORY_LEN-2:0],
                                 resolve_taken};
            end else begin
                if (do_pop) begin
                    head <= head + 1'b1;
                end
                if (do_push) begin
                    pc_mem[tail]   <= push_pc;
                    hist_mem[tail] <= spec_history;
                    pred_mem[tail] <= push_prediction;
                    tail           <= tail + 1'b1;
                    spec_history   <= {spec_history[HISTORY_LEN-2:0],
                                       push_prediction};
                end
            end
        end
    end

    // Update port: strobes pulse for one cycle, payload holds its last value.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            upd_write_enabled <= 1'b0;
            upd_pc            <= '0;
            upd_history       <= '0;
            upd_outcome       <= 1'b0;
            mispredict        <= 1'b0;
            resolve_err       <= 1'b0;
        end else begin
            upd_write_enabled <= do_resolve;
            mispredict        <= do_mis;
            resolve_err       <= resolve_valid && empty;
            if (do_resolve) begin
                upd_pc      <= pc_mem[head];
                upd_history <= hist_mem[head];
                upd_outcome <= resolve_taken;
            end
        end
    end

endmodule
